// File: rtl/lenet_downsampler.sv
// rtl/lenet_downsampler.sv - box-sum downsampler: centred fb1 window -> lenet_size^2 thresholded map in fb3
// One fb1 read per cycle in SCAN; a one-stage pipeline folds each pixel into a per-column block accumulator.
module lenet_downsampler #(
   parameter int         width        = 640,
   parameter int         height       = 480,
   parameter int         widthlength  = 8,
   parameter int         heightlength = 8,
   parameter int         lenet_size   = 28,
   parameter logic [9:0] threshold    = 10'd384
) (
   input  logic        clk25,
   input  logic        rst_n,
   input  logic        lenet_signal,
   output logic [18:0] addr_mem0,
   input  logic [7:0]  din,
   output logic [9:0]  addr_mem2,
   output logic [7:0]  lenet_dout,
   output logic        lenet_we,
   output logic        busy,
   output logic        data_ready
);

   localparam int ACC_W    = $clog2(widthlength*heightlength) + 4;
   localparam int WIN_W    = lenet_size*widthlength;
   localparam int WIN_H    = lenet_size*heightlength;
   localparam int X0       = (width - WIN_W)/2;
   localparam int Y0       = (height - WIN_H)/2;
   localparam int ORIGIN   = Y0*width + X0;
   localparam int ROW_STEP = width - WIN_W + 1;
   localparam int PXW      = (widthlength  > 1) ? $clog2(widthlength)  : 1;
   localparam int PYW      = (heightlength > 1) ? $clog2(heightlength) : 1;
   localparam int BW       = (lenet_size   > 1) ? $clog2(lenet_size)   : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic             sig_q;
   logic [PXW-1:0]   px_q, px_d;
   logic [PYW-1:0]   py_q, py_d;
   logic [BW-1:0]    bcol_q, bcol_d;
   logic [BW-1:0]    brow_q, brow_d;
   logic [18:0]      addr0_q, addr0_d;
   logic             s1_valid_q, s1_valid_d;
   logic             s1_close_q, s1_close_d;
   logic [BW-1:0]    s1_bcol_q, s1_bcol_d;
   logic [BW-1:0]    s1_brow_q, s1_brow_d;
   logic             we_q, we_d;
   logic [9:0]       addr2_q, addr2_d;
   logic [7:0]       dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic [ACC_W-1:0] acc_q [lenet_size];
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] acc_wval;
   logic             start;
   logic             px_last, py_last, bcol_last, brow_last, scan_last;
   logic             unused_din_lsbs;

   assign unused_din_lsbs = ^din[3:0];
   assign start     = lenet_signal & ~sig_q;
   assign px_last   = (px_q   == PXW'(widthlength - 1));
   assign py_last   = (py_q   == PYW'(heightlength - 1));
   assign bcol_last = (bcol_q == BW'(lenet_size - 1));
   assign brow_last = (brow_q == BW'(lenet_size - 1));
   assign scan_last = px_last & py_last & bcol_last & brow_last;

   // The closing pixel is forwarded into the sum the same cycle its block is emitted.
   assign sum      = acc_q[s1_bcol_q] + ACC_W'(din[7:4]);
   assign acc_wval = s1_close_q ? '0 : sum;

   always_comb begin
      state_d    = state_q;
      px_d       = px_q;
      py_d       = py_q;
      bcol_d     = bcol_q;
      brow_d     = brow_q;
      addr0_d    = addr0_q;
      s1_valid_d = 1'b0;
      s1_close_d = 1'b0;
      s1_bcol_d  = s1_bcol_q;
      s1_brow_d  = s1_brow_q;
      we_d       = 1'b0;
      addr2_d    = addr2_q;
      dout_d     = dout_q;
      busy_d     = busy_q;
      ready_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SCAN;
               busy_d  = 1'b1;
               addr0_d = 19'(ORIGIN);
               px_d    = '0;
               py_d    = '0;
               bcol_d  = '0;
               brow_d  = '0;
            end
         end
         ST_SCAN: begin
            s1_valid_d = 1'b1;
            s1_close_d = px_last & py_last;
            s1_bcol_d  = bcol_q;
            s1_brow_d  = brow_q;
            if (px_last) begin
               px_d = '0;
               if (bcol_last) begin
                  bcol_d  = '0;
                  addr0_d = addr0_q + 19'(ROW_STEP);
                  if (py_last) begin
                     py_d   = '0;
                     brow_d = brow_q + 1'b1;
                  end else begin
                     py_d = py_q + 1'b1;
                  end
               end else begin
                  bcol_d  = bcol_q + 1'b1;
                  addr0_d = addr0_q + 19'd1;
               end
            end else begin
               px_d    = px_q + 1'b1;
               addr0_d = addr0_q + 19'd1;
            end
            // The address counters wrap here but addr_mem0 must keep the last address.
            if (scan_last) begin
               state_d = ST_DRAIN;
               addr0_d = addr0_q;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      endcase

      if (s1_valid_q && s1_close_q) begin
         we_d    = 1'b1;
         addr2_d = 10'(s1_brow_q)*10'(lenet_size) + 10'(s1_bcol_q);
         dout_d  = (int'(sum) >= int'(threshold)) ? sum[ACC_W-1 -: 8] : 8'd0;
      end
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sig_q      <= 1'b0;
         px_q       <= '0;
         py_q       <= '0;
         bcol_q     <= '0;
         brow_q     <= '0;
         addr0_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_close_q <= 1'b0;
         s1_bcol_q  <= '0;
         s1_brow_q  <= '0;
         we_q       <= 1'b0;
         addr2_q    <= '0;
         dout_q     <= '0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         for (int i = 0; i < lenet_size; i++) acc_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         sig_q      <= lenet_signal;
         px_q       <= px_d;
         py_q       <= py_d;
         bcol_q     <= bcol_d;
         brow_q     <= brow_d;
         addr0_q    <= addr0_d;
         s1_valid_q <= s1_valid_d;
         s1_close_q <= s1_close_d;
         s1_bcol_q  <= s1_bcol_d;
         s1_brow_q  <= s1_brow_d;
         we_q       <= we_d;
         addr2_q    <= addr2_d;
         dout_q     <= dout_d;
         busy_q     <= busy_d;
         ready_q    <= ready_d;
         if (s1_valid_q) acc_q[s1_bcol_q] <= acc_wval;
      end
   end

   assign addr_mem0  = addr0_q;
   assign addr_mem2  = addr2_q;
   assign lenet_dout = dout_q;
   assign lenet_we   = we_q;
   assign busy       = busy_q;
   assign data_ready = ready_q;

endmodule

// File: tb/tb_lenet_downsampler.sv
// tb/tb_lenet_downsampler.sv - randomized self-checking bench for lenet_downsampler against a block-sum model
module tb_lenet_downsampler;

   localparam int TW    = 80;
   localparam int TH    = 60;
   localparam int WL    = 4;
   localparam int HL    = 4;
   localparam int L     = 8;
   localparam int THR   = 96;
   localparam int ACC_W = $clog2(WL*HL) + 4;
   localparam int WIN_W = L*WL;
   localparam int WIN_H = L*HL;
   localparam int N     = WIN_W*WIN_H;
   localparam int X0    = (TW - WIN_W)/2;
   localparam int Y0    = (TH - WIN_H)/2;

   logic        clk25 = 1'b0;
   logic        rst_n;
   logic        lenet_signal;
   logic [18:0] addr_mem0;
   logic [7:0]  din;
   logic [9:0]  addr_mem2;
   logic [7:0]  lenet_dout;
   logic        lenet_we;
   logic        busy;
   logic        data_ready;

   lenet_downsampler #(
      .width(TW), .height(TH), .widthlength(WL), .heightlength(HL),
      .lenet_size(L), .threshold(10'(THR))
   ) dut (
      .clk25(clk25), .rst_n(rst_n), .lenet_signal(lenet_signal),
      .addr_mem0(addr_mem0), .din(din), .addr_mem2(addr_mem2),
      .lenet_dout(lenet_dout), .lenet_we(lenet_we), .busy(busy),
      .data_ready(data_ready)
   );

   always #20 clk25 = ~clk25;

   int          n_vec = 0;
   int          n_bad = 0;
   int          mode;
   logic [7:0]  cval;
   logic [31:0] seed;
   int          exp_map [L*L];
   int          wr_a [$];
   int          wr_d [$];
   int          rd_addr;
   bit          active;
   int          t_cnt, first_addr, last_addr, addr_err, ready_cnt, ready_t;
   logic        busy_at_ready;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int a);
      int          x;
      logic [31:0] h;
      x = a % TW;
      h = (32'(a) * 32'h9E37_79B1) ^ seed;
      case (mode)
         0:       return cval;
         1:       return (x >= X0 + 3*WL && x < X0 + 4*WL) ? 8'hF0 : 8'h00;
         default: return {4'(h[23:16] % 8'd13), h[3:0]};
      endcase
   endfunction

   function automatic void build_model();
      for (int br = 0; br < L; br++)
         for (int bc = 0; bc < L; bc++) begin
            int s;
            logic [7:0] p;
            s = 0;
            for (int r = 0; r < HL; r++)
               for (int c = 0; c < WL; c++) begin
                  p = pix((Y0 + br*HL + r)*TW + X0 + bc*WL + c);
                  s += int'(p[7:4]);
               end
            exp_map[br*L + bc] = (s >= THR) ? ((s >> (ACC_W - 8)) & 255) : 0;
         end
   endfunction

   // fb1: synchronous read, data for the address seen in cycle t appears in cycle t+1
   always @(negedge clk25) rd_addr = int'(addr_mem0);
   always @(posedge clk25) begin
      #1;
      din = pix(rd_addr);
   end

   always @(negedge clk25) begin
      if (!rst_n) begin
         active = 1'b0;
      end else begin
         if (busy && !active) begin
            active     = 1'b1;
            t_cnt      = 0;
            first_addr = int'(addr_mem0);
         end
         if (active) begin
            if (t_cnt < N) begin
               if (int'(addr_mem0) != (Y0 + t_cnt/WIN_W)*TW + X0 + t_cnt%WIN_W) addr_err++;
               last_addr = int'(addr_mem0);
            end
            if (lenet_we) begin
               wr_a.push_back(int'(addr_mem2));
               wr_d.push_back(int'(lenet_dout));
            end
            if (data_ready) begin
               ready_cnt++;
               ready_t       = t_cnt;
               busy_at_ready = busy;
               active        = 1'b0;
            end
            t_cnt++;
         end else if (data_ready) begin
            ready_cnt++;
         end
      end
   end

   task automatic arm();
      wr_a.delete();
      wr_d.delete();
      ready_cnt = 0;
      ready_t   = -1;
      addr_err  = 0;
      busy_at_ready = 1'bx;
   endtask

   task automatic run_conv(input int m, input logic [7:0] cv, input bit retrig, input string tag);
      int nw;
      mode = m;
      cval = cv;
      seed = $urandom;
      build_model();
      arm();
      lenet_signal = 1'b0;
      repeat (3) @(posedge clk25);
      #1 lenet_signal = 1'b1;
      if (retrig) begin
         repeat (100) @(posedge clk25);
         #1 lenet_signal = 1'b0;
         repeat (3) @(posedge clk25);
         #1 lenet_signal = 1'b1;
      end
      for (int i = 0; i < N + 200 && ready_cnt == 0; i++) @(posedge clk25);
      repeat (20) @(posedge clk25);
      chk({tag, " ready_count"}, ready_cnt, 1);
      chk({tag, " ready_cycle"}, ready_t, N + 2);
      chk({tag, " busy_at_ready"}, int'(busy_at_ready), 0);
      chk({tag, " first_addr"}, first_addr, Y0*TW + X0);
      chk({tag, " last_addr"}, last_addr, (Y0 + WIN_H - 1)*TW + X0 + WIN_W - 1);
      chk({tag, " addr_seq_errors"}, addr_err, 0);
      chk({tag, " write_count"}, wr_a.size(), L*L);
      nw = (wr_a.size() < L*L) ? wr_a.size() : L*L;
      for (int i = 0; i < nw; i++) begin
         chk($sformatf("%s waddr[%0d]", tag, i), wr_a[i], i);
         chk($sformatf("%s wdata[%0d]", tag, i), wr_d[i], exp_map[i]);
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, " addr_mem0"},  int'(addr_mem0), 0);
      chk({tag, " addr_mem2"},  int'(addr_mem2), 0);
      chk({tag, " lenet_dout"}, int'(lenet_dout), 0);
      chk({tag, " lenet_we"},   int'(lenet_we), 0);
      chk({tag, " busy"},       int'(busy), 0);
      chk({tag, " data_ready"}, int'(data_ready), 0);
   endtask

   initial begin
      rst_n        = 1'b0;
      lenet_signal = 1'b0;
      din          = 8'h00;
      mode         = 0;
      cval         = 8'h00;
      seed         = 32'h0;
      active       = 1'b0;
      arm();
      repeat (3) @(posedge clk25);
      #5 chk_outputs_zero("reset");
      @(posedge clk25);
      #1 rst_n = 1'b1;

      run_conv(0, 8'hFF, 1'b0, "ff");
      run_conv(0, 8'h00, 1'b0, "zero");
      run_conv(0, 8'h60, 1'b0, "thr_at");
      run_conv(0, 8'h5F, 1'b0, "thr_below");
      run_conv(1, 8'h00, 1'b0, "stripe");
      run_conv(2, 8'h00, 1'b0, "rand_a");
      run_conv(2, 8'h00, 1'b1, "retrig");

      // abort a conversion part-way with reset
      mode = 0;
      cval = 8'hFF;
      arm();
      lenet_signal = 1'b0;
      repeat (3) @(posedge clk25);
      #1 lenet_signal = 1'b1;
      repeat (N/5) @(posedge clk25);
      #1 rst_n = 1'b0;
      #3 chk_outputs_zero("midreset");
      lenet_signal = 1'b0;
      repeat (3) @(posedge clk25);
      #1 rst_n = 1'b1;
      repeat (50) @(posedge clk25);
      chk("midreset no_ready", ready_cnt, 0);
      chk("midreset busy_after", int'(busy), 0);

      run_conv(2, 8'h00, 1'b0, "fresh");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
